// File: rtl/random_read_data_sink_pkg.sv
// Shared types and constants for the random read-data sink and its
// companion write-data path.
package random_read_data_sink_pkg;

    typedef enum logic [1:0] {
        SINK_IDLE = 2'd0,
        SINK_RUN  = 2'd1,
        SINK_DONE = 2'd2
    } sink_state_t;

    localparam int ERR_LEN   = 0;
    localparam int ERR_STRAY = 1;
    localparam int ERR_UFLOW = 2;
    localparam int ERR_OVER  = 3;
    localparam int ERR_BITS  = 4;

endpackage

// File: rtl/random_read_data_sink_if.sv
// AXI4-Stream read-data channel as seen by the sink.
interface random_read_data_sink_if #(
    parameter int DATA_BITS = 512
);
    logic [DATA_BITS-1:0]   tdata;
    logic [DATA_BITS/8-1:0] tkeep;
    logic                   tlast;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/random_read_data_sink_popcount.sv
// Combinational count of set byte-enable bits; shared with the write-data path.
module keep_popcount #(
    parameter int W = 64
) (
    input  logic [W-1:0]       keep,
    output logic [$clog2(W):0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + {{$clog2(W){1'b0}}, keep[i]};
        end
    end
endmodule

// File: rtl/random_read_data_sink.sv
// Read-data sink: drains the stream, counts beats/bytes/requests, checks
// per-request length and reports run time for bandwidth measurement.
module random_read_data_sink
    import random_read_data_sink_pkg::*;
#(
    parameter int DATA_BITS = 512,
    parameter int CNT_BITS  = 64
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [63:0]               num_requests,
    input  logic [63:0]               req_size,
    input  logic                      ap_start,
    input  logic                      req_issued,
    random_read_data_sink_if.slave    s_axis,
    output logic                      ap_done,
    output logic [CNT_BITS-1:0]       bytes_received,
    output logic [CNT_BITS-1:0]       beats_received,
    output logic [CNT_BITS-1:0]       reqs_completed,
    output logic [CNT_BITS-1:0]       run_cycles,
    output logic [31:0]               outstanding,
    output logic [ERR_BITS-1:0]       err
);
    localparam int KEEP_BITS = DATA_BITS / 8;
    localparam int PC_BITS   = $clog2(KEEP_BITS) + 1;
    localparam int CMP_BITS  = (CNT_BITS > 64) ? CNT_BITS : 64;

    sink_state_t        state, state_next;
    logic               ap_start_r, start_pulse, in_run;
    logic               beat, last_beat, reqs_hit, reqs_over;
    logic [63:0]        num_req_latched, req_size_latched, pkt_bytes, pkt_total;
    logic [64:0]        pkt_sum;
    logic [PC_BITS-1:0] beat_bytes;

    function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                    input logic [CNT_BITS-1:0] b);
        logic [CNT_BITS:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_BITS] ? '1 : sum[CNT_BITS-1:0];
    endfunction

    keep_popcount #(.W(KEEP_BITS)) u_popcount (
        .keep  (s_axis.tkeep),
        .count (beat_bytes)
    );

    assign start_pulse = ap_start & ~ap_start_r;
    assign beat        = s_axis.tvalid & s_axis.tready;
    assign last_beat   = beat & s_axis.tlast;
    assign pkt_sum     = {1'b0, pkt_bytes} + 65'(beat_bytes);
    assign pkt_total   = pkt_sum[64] ? '1 : pkt_sum[63:0];
    assign reqs_hit    = CMP_BITS'(reqs_completed) == CMP_BITS'(num_req_latched);
    assign reqs_over   = CMP_BITS'(reqs_completed) >= CMP_BITS'(num_req_latched);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= SINK_IDLE;
        else          state <= state_next;
    end

    // Completion is judged on the registered count, so DONE lags the last beat by one cycle.
    always_comb begin
        state_next = state;
        case (state)
            SINK_IDLE: if (start_pulse) state_next = SINK_RUN;
            SINK_RUN:  if (reqs_hit)    state_next = SINK_DONE;
            SINK_DONE: if (start_pulse) state_next = SINK_RUN;
            default:                    state_next = SINK_IDLE;
        endcase
    end

    always_comb begin
        in_run  = (state == SINK_RUN);
        ap_done = (state == SINK_DONE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_axis.tready    <= 1'b0;
            ap_start_r       <= 1'b0;
            num_req_latched  <= '0;
            req_size_latched <= '0;
            pkt_bytes        <= '0;
            bytes_received   <= '0;
            beats_received   <= '0;
            reqs_completed   <= '0;
            run_cycles       <= '0;
            outstanding      <= '0;
            err              <= '0;
        end else begin
            s_axis.tready <= 1'b1;
            ap_start_r    <= ap_start;
            if (start_pulse && !in_run) begin
                num_req_latched  <= num_requests;
                req_size_latched <= req_size;
                pkt_bytes        <= '0;
                bytes_received   <= '0;
                beats_received   <= '0;
                reqs_completed   <= '0;
                run_cycles       <= '0;
                outstanding      <= '0;
                err              <= '0;
            end else if (in_run) begin
                run_cycles <= sat_add(run_cycles, CNT_BITS'(1));
                if (beat) begin
                    beats_received <= sat_add(beats_received, CNT_BITS'(1));
                    bytes_received <= sat_add(bytes_received, CNT_BITS'(beat_bytes));
                    pkt_bytes      <= last_beat ? '0 : pkt_total;
                end
                if (last_beat) begin
                    reqs_completed <= sat_add(reqs_completed, CNT_BITS'(1));
                    if (pkt_total != req_size_latched) err[ERR_LEN] <= 1'b1;
                    if (reqs_over) err[ERR_OVER] <= 1'b1;
                end
                // A same-cycle issue and completion cancel out.
                if (req_issued && !last_beat) begin
                    if (outstanding != '1) outstanding <= outstanding + 32'd1;
                end else if (last_beat && !req_issued) begin
                    if (outstanding == '0) err[ERR_UFLOW] <= 1'b1;
                    else                   outstanding <= outstanding - 32'd1;
                end
            end else if (beat) begin
                err[ERR_STRAY] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_random_read_data_sink.sv
// Randomised and directed bench for random_read_data_sink against a
// cycle-level behavioural model of the run/count rules.
module tb_random_read_data_sink;
    localparam int DATA_BITS = 512;
    localparam int KEEP_BITS = DATA_BITS / 8;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [63:0] num_requests = '0;
    logic [63:0] req_size = '0;
    logic        ap_start = 1'b0;
    logic        req_issued = 1'b0;
    logic        ap_done;
    logic [63:0] bytes_received, beats_received, reqs_completed, run_cycles;
    logic [31:0] outstanding;
    logic [3:0]  err;

    int total = 0;
    int bad = 0;

    random_read_data_sink_if #(.DATA_BITS(DATA_BITS)) s_if ();

    random_read_data_sink #(.DATA_BITS(DATA_BITS), .CNT_BITS(64)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .num_requests   (num_requests),
        .req_size       (req_size),
        .ap_start       (ap_start),
        .req_issued     (req_issued),
        .s_axis         (s_if),
        .ap_done        (ap_done),
        .bytes_received (bytes_received),
        .beats_received (beats_received),
        .reqs_completed (reqs_completed),
        .run_cycles     (run_cycles),
        .outstanding    (outstanding),
        .err            (err)
    );

    always #5 aclk = ~aclk;

    // Behavioural model: run flag plus plain integer tallies.
    bit              m_ready, m_start_prev, m_running, m_done;
    longint unsigned m_num, m_size, m_bytes, m_beats, m_reqs, m_cycles, m_pkt;
    int unsigned     m_out;
    logic [3:0]      m_err;
    bit              t_start, t_beat, t_last, t_finish;
    int              t_kb;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_ready = 0; m_start_prev = 0; m_running = 0; m_done = 0;
            m_num = 0; m_size = 0; m_bytes = 0; m_beats = 0; m_reqs = 0;
            m_cycles = 0; m_pkt = 0; m_out = 0; m_err = '0;
        end else begin
            t_start = ap_start && !m_start_prev;
            t_beat  = s_if.tvalid && m_ready;
            t_last  = t_beat && s_if.tlast;
            t_kb    = $countones(s_if.tkeep);
            if (m_running) begin
                t_finish = (m_reqs == m_num);
                m_cycles++;
                if (t_beat) begin
                    m_beats++;
                    m_bytes += longint'(t_kb);
                end
                if (t_last) begin
                    if (m_pkt + longint'(t_kb) != m_size) m_err[0] = 1'b1;
                    if (m_reqs + 1 > m_num) m_err[3] = 1'b1;
                    m_reqs++;
                    m_pkt = 0;
                end else if (t_beat) begin
                    m_pkt += longint'(t_kb);
                end
                if (req_issued && !t_last) m_out++;
                else if (t_last && !req_issued) begin
                    if (m_out == 0) m_err[2] = 1'b1;
                    else            m_out--;
                end
                if (t_finish) begin
                    m_running = 0;
                    m_done = 1;
                end
            end else if (t_start) begin
                m_running = 1; m_done = 0;
                m_num = num_requests; m_size = req_size;
                m_bytes = 0; m_beats = 0; m_reqs = 0; m_cycles = 0;
                m_pkt = 0; m_out = 0; m_err = '0;
            end else if (t_beat) begin
                m_err[1] = 1'b1;
            end
            m_start_prev = ap_start;
            m_ready = 1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge aclk) begin
        checkOutput("tready",      64'(s_if.tready),   64'(m_ready));
        checkOutput("ap_done",     64'(ap_done),       64'(m_done));
        checkOutput("bytes",       bytes_received,     m_bytes);
        checkOutput("beats",       beats_received,     m_beats);
        checkOutput("reqs",        reqs_completed,     m_reqs);
        checkOutput("run_cycles",  run_cycles,         m_cycles);
        checkOutput("outstanding", 64'(outstanding),   64'(m_out));
        checkOutput("err",         64'(err),           64'(m_err));
    end

    function automatic logic [KEEP_BITS-1:0] makeKeep(input int n);
        logic [KEEP_BITS-1:0] m;
        int r;
        m = (n >= KEEP_BITS) ? '1 : ((64'd1 << n) - 64'd1);
        r = $urandom_range(0, KEEP_BITS - 1);
        return (m << r) | (m >> (KEEP_BITS - r));
    endfunction

    // One clock of stimulus; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input bit valid, input logic [KEEP_BITS-1:0] keep,
                                 input bit last, input bit issued);
        s_if.tvalid = valid;
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        s_if.tdata  = {16{$urandom()}};
        req_issued  = issued;
        @(posedge aclk);
        #1;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        req_issued  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0);
    endtask

    task automatic startRun(input longint unsigned n, input longint unsigned size);
        num_requests = n;
        req_size     = size;
        ap_start     = 1'b1;
        applyStimulus(0, '0, 0, 0);
        ap_start     = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 20 && !ap_done; i++) applyStimulus(0, $urandom(), $urandom_range(0, 1), 0);
        total++;
        if (!ap_done) begin
            bad++;
            $display("[TB] FAIL %s: ap_done still 0 after 20 cycles", name);
        end
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tkeep  = '0;
        s_if.tdata  = '0;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_tready", 64'(s_if.tready), 64'd0);
        checkOutput("rst_done",   64'(ap_done),     64'd0);
        checkOutput("rst_bytes",  bytes_received,   64'd0);
        aresetn = 1'b1;
        idle(1);
        checkOutput("ready_after_rst", 64'(s_if.tready), 64'd1);

        // Stray beat while IDLE
        applyStimulus(1, makeKeep(64), 1, 0);
        checkOutput("idle_stray_err",   64'(err),       64'd2);
        checkOutput("idle_stray_beats", beats_received, 64'd0);

        // Four 2-beat full packets of 128 bytes
        startRun(4, 128);
        checkOutput("start_clears_err", 64'(err), 64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, 0, 1);
        checkOutput("outstanding_4", 64'(outstanding), 64'd4);
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1, makeKeep(64), 0, 0);
            applyStimulus(1, makeKeep(64), 1, 0);
        end
        checkOutput("done_lag1", 64'(ap_done), 64'd0);
        checkOutput("reqs_4",    reqs_completed, 64'd4);
        idle(1);
        checkOutput("done_lag2", 64'(ap_done), 64'd1);
        checkOutput("bytes_512", bytes_received, 64'd512);
        checkOutput("beats_8",   beats_received, 64'd8);
        checkOutput("err_0",     64'(err), 64'd0);

        // Partial keeps; second packet one byte short
        startRun(2, 100);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(1, makeKeep(64), 0, 0);
        applyStimulus(1, makeKeep(36), 1, 0);
        checkOutput("len_ok_err", 64'(err), 64'd0);
        applyStimulus(1, makeKeep(64), 0, 0);
        applyStimulus(1, makeKeep(35), 1, 0);
        waitDone("len_run_done");
        checkOutput("len_err",   64'(err), 64'd1);
        checkOutput("bytes_199", bytes_received, 64'd199);

        // Stray beat after DONE
        applyStimulus(1, makeKeep(64), 1, 0);
        checkOutput("done_stray_err",   64'(err),       64'd3);
        checkOutput("done_stray_beats", beats_received, 64'd4);
        checkOutput("done_stray_ready", 64'(s_if.tready), 64'd1);

        // Simultaneous issue and completion
        startRun(3, 64);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(1, makeKeep(64), 1, 1);
        checkOutput("out_hold_2", 64'(outstanding), 64'd2);
        applyStimulus(1, makeKeep(64), 1, 0);
        applyStimulus(1, makeKeep(64), 1, 0);
        waitDone("overlap_done");
        checkOutput("out_zero", 64'(outstanding), 64'd0);

        // Completion with nothing outstanding
        startRun(2, 64);
        applyStimulus(1, makeKeep(64), 1, 0);
        checkOutput("uflow_err", 64'(err), 64'd4);
        checkOutput("uflow_out", 64'(outstanding), 64'd0);
        applyStimulus(1, makeKeep(64), 1, 0);
        waitDone("uflow_done");

        // Extra completion in the lag cycle before DONE
        startRun(1, 64);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(1, makeKeep(64), 1, 0);
        applyStimulus(1, makeKeep(64), 1, 0);
        checkOutput("over_err",  64'(err), 64'd8);
        checkOutput("over_reqs", reqs_completed, 64'd2);

        // Zero-request run with ap_start held high
        num_requests = 0;
        req_size     = 0;
        ap_start     = 1'b1;
        idle(1);
        checkOutput("zero_done_lag1", 64'(ap_done), 64'd0);
        idle(1);
        checkOutput("zero_done",   64'(ap_done), 64'd1);
        checkOutput("zero_cycles", run_cycles, 64'd1);
        idle(8);
        checkOutput("held_start_done",   64'(ap_done), 64'd1);
        checkOutput("held_start_cycles", run_cycles, 64'd1);
        ap_start = 1'b0;
        idle(1);

        // Asynchronous reset mid-run
        startRun(4, 128);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(1, makeKeep(64), 0, 0);
        applyStimulus(1, makeKeep(64), 1, 0);
        applyStimulus(1, makeKeep(64), 0, 0);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("arst_bytes",  bytes_received, 64'd0);
        checkOutput("arst_beats",  beats_received, 64'd0);
        checkOutput("arst_reqs",   reqs_completed, 64'd0);
        checkOutput("arst_cycles", run_cycles, 64'd0);
        checkOutput("arst_out",    64'(outstanding), 64'd0);
        checkOutput("arst_ready",  64'(s_if.tready), 64'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        idle(1);
        startRun(2, 128);
        applyStimulus(0, '0, 0, 1);
        applyStimulus(0, '0, 0, 1);
        for (int p = 0; p < 2; p++) begin
            applyStimulus(1, makeKeep(64), 0, 0);
            applyStimulus(1, makeKeep(64), 1, 0);
        end
        waitDone("post_rst_done");
        checkOutput("post_rst_bytes", bytes_received, 64'd256);
        checkOutput("post_rst_err",   64'(err), 64'd0);

        // Randomised runs
        for (int run = 0; run < 8; run++) begin
            int n, size, target, remaining, k, issue_left;
            n = $urandom_range(1, 5);
            size = $urandom_range(2, 300);
            startRun(longint'(n), longint'(size));
            issue_left = n;
            for (int p = 0; p < n; p++) begin
                target = size;
                if ($urandom_range(0, 3) == 0) target = ($urandom_range(0, 1) == 1) ? size + 1 : size - 1;
                remaining = target;
                while (remaining > 0) begin
                    k = $urandom_range(1, (remaining < KEEP_BITS) ? remaining : KEEP_BITS);
                    remaining -= k;
                    applyStimulus(1, makeKeep(k), remaining == 0,
                                  issue_left > 0 && $urandom_range(0, 2) == 0);
                    if (req_issued == 1'b0 && issue_left > 0 && $urandom_range(0, 1) == 0) issue_left--;
                    if ($urandom_range(0, 3) == 0) applyStimulus(0, $urandom(), $urandom_range(0, 1), 0);
                end
            end
            waitDone("rand_done");
            if ($urandom_range(0, 1) == 1) applyStimulus(1, makeKeep($urandom_range(1, 64)), 1, 0);
            idle(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
